// File: rtl/sum_display_pkg.sv
// Shared types and constants for the BCD sum display: FSM states, segment
// patterns and the double-dabble helper.
package sum_display_pkg;

  localparam int SUM_W    = 5;
  localparam int BCD_ITER = 5;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low gfedcba patterns for digits 0..9
  localparam logic [6:0] SEG_PATTERN [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [3:0] dabble_adjust(input logic [3:0] digit);
    return (digit >= 4'd5) ? (digit + 4'd3) : digit;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment decoder with blanking; non-decimal
// codes decode to all segments off.
module seg7_decode
  import sum_display_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] pattern;

  always_comb begin
    pattern = SEG_OFF;
    if (blank) begin
      pattern = SEG_OFF;
    end else if (digit <= 4'd9) begin
      pattern = SEG_PATTERN[digit];
    end else begin
      pattern = SEG_OFF;
    end
    seg = (SEG_ACTIVE_LOW != 0) ? pattern : ~pattern;
  end

endmodule

// File: rtl/sum_bcd_display.sv
// Captures the adder sum on request, converts it to BCD one bit per cycle and
// drives a two-digit multiplexed common-anode display with tens blanking.
module sum_bcd_display
  import sum_display_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             load,
  output logic             busy,
  output logic             valid,
  output logic [6:0]       seg,
  output logic [1:0]       an
);

  localparam int              REF_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_DARK = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;

  state_t           state_r, state_next;
  logic [SUM_W-1:0] shreg_r;
  logic [3:0]       ones_r, ones_adj;
  logic [1:0]       tens_r;
  logic [CNT_W-1:0] iter_r;
  logic [3:0]       disp_ones_r;
  logic [1:0]       disp_tens_r;
  logic             valid_r, busy_r;
  logic [REF_W-1:0] refresh_r;
  logic             sel_r;
  logic [3:0]       digit;
  logic             blank;
  logic [1:0]       an_next;
  logic [6:0]       seg_next;
  logic [6:0]       seg_r;
  logic [1:0]       an_r;

  assign ones_adj = dabble_adjust(ones_r);

  // SHIFT lingers one cycle after the last iteration so the display commits 7 edges after capture
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE:    if (load) state_next = SHIFT; else state_next = IDLE;
      SHIFT:   if (iter_r == CNT_W'(BCD_ITER)) state_next = DONE; else state_next = SHIFT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      shreg_r     <= '0;
      ones_r      <= 4'd0;
      tens_r      <= 2'd0;
      iter_r      <= '0;
      disp_ones_r <= 4'd0;
      disp_tens_r <= 2'd0;
      valid_r     <= 1'b0;
    end else begin
      state_r <= state_next;
      busy_r  <= (state_r != IDLE) && (state_next != IDLE);
      case (state_r)
        IDLE: begin
          if (load) begin
            shreg_r <= sum_in;
            ones_r  <= 4'd0;
            tens_r  <= 2'd0;
            iter_r  <= '0;
          end
        end
        SHIFT: begin
          if (iter_r != CNT_W'(BCD_ITER)) begin
            {tens_r, ones_r, shreg_r} <= {tens_r[0], ones_adj, shreg_r, 1'b0};
            iter_r <= iter_r + 3'd1;
          end
        end
        DONE: begin
          disp_ones_r <= ones_r;
          disp_tens_r <= tens_r;
          valid_r     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_r <= '0;
      sel_r     <= 1'b0;
    end else if (refresh_r == REF_LAST) begin
      refresh_r <= '0;
      sel_r     <= ~sel_r;
    end else begin
      refresh_r <= refresh_r + 1'b1;
    end
  end

  always_comb begin
    digit   = sel_r ? {2'b00, disp_tens_r} : disp_ones_r;
    blank   = !valid_r || (sel_r && (disp_tens_r == 2'd0));
    an_next = blank ? 2'b11 : (sel_r ? 2'b01 : 2'b10);
  end

  seg7_decode #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_decode (
    .digit(digit),
    .blank(blank),
    .seg  (seg_next)
  );

  // seg and an share one register stage so they always switch together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= SEG_DARK;
      an_r  <= 2'b11;
    end else begin
      seg_r <= seg_next;
      an_r  <= an_next;
    end
  end

  assign busy  = busy_r;
  assign valid = valid_r;
  assign seg   = seg_r;
  assign an    = an_r;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Self-checking bench: directed scenarios plus random loads, compared every
// cycle against a timeline model of conversions and the digit multiplex.
module tb_sum_bcd_display;

  localparam int RDIV = 4;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [4:0] sum_in = 5'd0;
  logic       load   = 1'b0;
  wire        busy, valid;
  wire [6:0]  seg;
  wire [1:0]  an;

  int checks = 0;
  int errors = 0;

  logic [6:0] pat [10];

  always #5 clk = ~clk;

  sum_bcd_display #(
    .REFRESH_DIV   (RDIV),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sum_in(sum_in),
    .load  (load),
    .busy  (busy),
    .valid (valid),
    .seg   (seg),
    .an    (an)
  );

  // Reference timeline: edge index k counts clock edges since reset release.
  // A load seen in idle at edge N is busy after N+1..N+6, shown from edge N+7,
  // and the engine is free again at edge N+8. Digit select after edge k is
  // ((k+1)/RDIV)%2; the outputs after edge k show the state before edge k.
  int m_edges, m_last_k, m_start, m_pend, m_val, m_out_val;
  bit m_inflight, m_valid, m_out_valid, m_out_sel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges     <= 0;
      m_last_k    <= -1;
      m_start     <= 0;
      m_pend      <= 0;
      m_val       <= 0;
      m_out_val   <= 0;
      m_inflight  <= 1'b0;
      m_valid     <= 1'b0;
      m_out_valid <= 1'b0;
      m_out_sel   <= 1'b0;
    end else begin
      m_out_sel   <= ((m_edges / RDIV) % 2) == 1;
      m_out_valid <= m_valid;
      m_out_val   <= m_val;
      m_last_k    <= m_edges;
      m_edges     <= m_edges + 1;
      if (m_inflight && m_edges == m_start + 7) begin
        m_valid <= 1'b1;
        m_val   <= m_pend;
      end
      if ((!m_inflight || m_edges >= m_start + 8) && load) begin
        m_inflight <= 1'b1;
        m_start    <= m_edges;
        m_pend     <= int'(sum_in);
      end
    end
  end

  task automatic check_outputs(input string tag);
    logic       exp_busy;
    logic [1:0] exp_an;
    logic [6:0] exp_seg;
    int         tens;
    exp_busy = m_inflight && (m_last_k >= m_start + 1) && (m_last_k <= m_start + 6);
    tens     = m_out_val / 10;
    if (!m_out_valid) begin
      exp_an  = 2'b11;
      exp_seg = 7'h7F;
    end else if (!m_out_sel) begin
      exp_an  = 2'b10;
      exp_seg = pat[m_out_val % 10];
    end else if (tens == 0) begin
      exp_an  = 2'b11;
      exp_seg = 7'h7F;
    end else begin
      exp_an  = 2'b01;
      exp_seg = pat[tens];
    end
    checks++;
    assert (busy === exp_busy) else begin
      errors++;
      $error("FAIL %s busy: observed %b expected %b", tag, busy, exp_busy);
    end
    checks++;
    assert (valid === m_valid) else begin
      errors++;
      $error("FAIL %s valid: observed %b expected %b", tag, valid, m_valid);
    end
    checks++;
    assert (an === exp_an) else begin
      errors++;
      $error("FAIL %s an: observed %b expected %b", tag, an, exp_an);
    end
    checks++;
    assert (seg === exp_seg) else begin
      errors++;
      $error("FAIL %s seg: observed %b expected %b", tag, seg, exp_seg);
    end
  endtask

  task automatic step(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs(tag);
    end
  endtask

  initial begin
    pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
    pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
    pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
    pat[9] = 7'b0010000;

    repeat (3) begin
      @(negedge clk);
      check_outputs("reset_hold");
    end
    rst_n = 1'b1;
    step(12, "idle_after_reset");

    sum_in = 5'd30; load = 1'b1;
    step(1, "sum30_load");
    load = 1'b0;
    step(20, "sum30");

    sum_in = 5'd9; load = 1'b1;
    step(1, "sum9_load");
    load = 1'b0;
    step(24, "sum9_tens_blank");

    sum_in = 5'd16; load = 1'b1;
    step(1, "sum16_load");
    load = 1'b0;
    step(1, "sum16_c1");
    sum_in = 5'd3;
    step(1, "sum16_c2");
    load = 1'b1;
    step(1, "sum16_busy_load");
    load = 1'b0;
    step(20, "sum16_hold");

    sum_in = 5'd15; load = 1'b1;
    step(1, "b2b_15_load");
    load = 1'b0;
    step(7, "b2b_15");
    sum_in = 5'd0; load = 1'b1;
    step(1, "b2b_0_load");
    load = 1'b0;
    step(20, "b2b_0");

    for (int i = 0; i < 16; i++) begin
      sum_in = 5'($urandom_range(30, 0));
      load   = 1'b1;
      step($urandom_range(3, 1), "rand_load");
      load   = 1'b0;
      sum_in = 5'($urandom_range(31, 0));
      step($urandom_range(14, 2), "rand_run");
    end
    load = 1'b1;
    sum_in = 5'd27;
    step(20, "held_load");
    load = 1'b0;
    step(10, "held_release");

    sum_in = 5'd22; load = 1'b1;
    step(1, "async_load");
    load = 1'b0;
    step(2, "async_shift");
    #2 rst_n = 1'b0;
    #1 check_outputs("async_reset");
    @(negedge clk);
    check_outputs("async_reset_held");
    rst_n = 1'b1;
    step(12, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
